// File: rtl/med_window3x3_if.sv
// Signal bundle of the 3x3 window stage: pixel input, line-buffer write/read taps and window output.
// master = upstream pixel source plus line buffers; slave = the window builder.
interface med_window3x3_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sof;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    lb_valid;
    logic [DATA_WIDTH-1:0]   lb_data;
    logic [DATA_WIDTH-1:0]   line1_data;
    logic [DATA_WIDTH-1:0]   line2_data;
    logic                    win_valid;
    logic [9*DATA_WIDTH-1:0] win_data;
    logic                    win_sof;
    logic                    win_eol;

    modport master (
        output in_valid, in_sof, in_data, line1_data, line2_data,
        input  in_ready, lb_valid, lb_data, win_valid, win_data, win_sof, win_eol
    );

    modport slave (
        input  in_valid, in_sof, in_data, line1_data, line2_data,
        output in_ready, lb_valid, lb_data, win_valid, win_data, win_sof, win_eol
    );
endinterface

// File: rtl/med_window3x3.sv
// 3x3 neighbourhood builder for the median filter; drives the line buffers and self-flushes row/frame edges.
// Build macro MEDWIN_ZERO_PAD_EN: out-of-frame taps read as 0 instead of being edge-replicated.
module med_window3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input logic            clk,
    input logic            rst,
    med_window3x3_if.slave pix_if
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_PAD  = ROW_W'(IMG_HEIGHT);

    typedef enum logic [1:0] {IDLE, RUN, COL_FLUSH, ROW_FLUSH} state_t;
    typedef logic [DATA_WIDTH-1:0] pix_t;

    function automatic pix_t oob_tap(input pix_t repl);
`ifdef MEDWIN_ZERO_PAD_EN
        return '0;
`else
        return repl;
`endif
    endfunction

    state_t                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    pix_t                    top0_q, top0_d, top1_q, top1_d;
    pix_t                    mid0_q, mid0_d, mid1_q, mid1_d;
    pix_t                    bot0_q, bot0_d, bot1_q, bot1_d;
    logic                    win_valid_q, win_valid_d;
    logic                    win_sof_q, win_sof_d;
    logic                    win_eol_q, win_eol_d;
    logic [9*DATA_WIDTH-1:0] win_data_q, win_data_d;

    logic in_ready;
    logic accept;
    logic lb_valid;
    pix_t lb_data;
    logic beat_win;
    logic flush_win;
    pix_t top_now, mid_now, bot_now;
    pix_t tl, tc, tr, ml, mc, mr, bl, bc, br;

    assign in_ready = (state_q == IDLE) || (state_q == RUN);
    assign accept   = pix_if.in_valid && in_ready;

    assign pix_if.in_ready  = in_ready;
    assign pix_if.lb_valid  = lb_valid;
    assign pix_if.lb_data   = lb_data;
    assign pix_if.win_valid = win_valid_q;
    assign pix_if.win_data  = win_data_q;
    assign pix_if.win_sof   = win_sof_q;
    assign pix_if.win_eol   = win_eol_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            top0_q      <= '0;
            top1_q      <= '0;
            mid0_q      <= '0;
            mid1_q      <= '0;
            bot0_q      <= '0;
            bot1_q      <= '0;
            win_valid_q <= 1'b0;
            win_sof_q   <= 1'b0;
            win_eol_q   <= 1'b0;
            win_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            top0_q      <= top0_d;
            top1_q      <= top1_d;
            mid0_q      <= mid0_d;
            mid1_q      <= mid1_d;
            bot0_q      <= bot0_d;
            bot1_q      <= bot1_d;
            win_valid_q <= win_valid_d;
            win_sof_q   <= win_sof_d;
            win_eol_q   <= win_eol_d;
            win_data_q  <= win_data_d;
        end
    end

    // row_q counts input rows; the value IMG_HEIGHT marks the replicated flush row.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        lb_valid  = 1'b0;
        lb_data   = pix_if.in_data;
        beat_win  = 1'b0;
        flush_win = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && pix_if.in_sof) begin
                    lb_valid = 1'b1;
                    state_d  = RUN;
                    row_d    = '0;
                    col_d    = COL_W'(1);
                end
            end
            RUN: begin
                if (accept) begin
                    lb_valid = 1'b1;
                    if (pix_if.in_sof) begin
                        row_d = '0;
                        col_d = COL_W'(1);
                    end else begin
                        beat_win = (row_q != '0) && (col_q != '0);
                        if (col_q == COL_LAST) begin
                            state_d = COL_FLUSH;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
            end
            COL_FLUSH: begin
                flush_win = (row_q != '0);
                col_d     = '0;
                if (row_q == ROW_LAST) begin
                    state_d = ROW_FLUSH;
                    row_d   = row_q + ROW_W'(1);
                end else if (row_q == ROW_PAD) begin
                    state_d = IDLE;
                    row_d   = '0;
                end else begin
                    state_d = RUN;
                    row_d   = row_q + ROW_W'(1);
                end
            end
            ROW_FLUSH: begin
                lb_valid = 1'b1;
                lb_data  = pix_if.line1_data;
                beat_win = (col_q != '0);
                if (col_q == COL_LAST) begin
                    state_d = COL_FLUSH;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift registers hold post-padding vertical taps, so stored columns are already edge-corrected.
    always_comb begin
        top_now = (row_q == ROW_W'(1)) ? oob_tap(pix_if.line1_data) : pix_if.line2_data;
        mid_now = pix_if.line1_data;
        bot_now = (state_q == ROW_FLUSH) ? oob_tap(pix_if.line1_data) : pix_if.in_data;

        top0_d = top0_q;
        top1_d = top1_q;
        mid0_d = mid0_q;
        mid1_d = mid1_q;
        bot0_d = bot0_q;
        bot1_d = bot1_q;
        if (lb_valid) begin
            top1_d = top0_q;
            top0_d = top_now;
            mid1_d = mid0_q;
            mid0_d = mid_now;
            bot1_d = bot0_q;
            bot0_d = bot_now;
        end

        if (flush_win) begin
            tl = top1_q;
            tc = top0_q;
            tr = oob_tap(top0_q);
            ml = mid1_q;
            mc = mid0_q;
            mr = oob_tap(mid0_q);
            bl = bot1_q;
            bc = bot0_q;
            br = oob_tap(bot0_q);
        end else begin
            tl = (col_q == COL_W'(1)) ? oob_tap(top0_q) : top1_q;
            tc = top0_q;
            tr = top_now;
            ml = (col_q == COL_W'(1)) ? oob_tap(mid0_q) : mid1_q;
            mc = mid0_q;
            mr = mid_now;
            bl = (col_q == COL_W'(1)) ? oob_tap(bot0_q) : bot1_q;
            bc = bot0_q;
            br = bot_now;
        end

        win_valid_d = beat_win || flush_win;
        win_sof_d   = beat_win && (row_q == ROW_W'(1)) && (col_q == COL_W'(1));
        win_eol_d   = flush_win;
        win_data_d  = win_data_q;
        if (beat_win || flush_win) begin
            win_data_d = {br, bc, bl, mr, mc, ml, tr, tc, tl};
        end
    end
endmodule
